homeostatic_resource: RTL and testbench

HOMEOSTATIC_RESOURCE -- requirements
Module: homeostatic_resource

---
 rtl/homeostatic_resource.sv | 127 ++++++++++++
 tb/tb_homeostatic_resource.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/homeostatic_resource.sv
// homeostatic_resource
//   A saturating N-bit resource value that is pushed up or down by requests
//   and, when left idle, drifts one step at a time back toward a baseline
//   (DEFAULT_VAL). One drift step happens every DECAY_PERIOD idle cycles.
//
// Ports
//   clk     : single clock, all state changes on the rising edge
//   rst     : synchronous active-high reset
//   inc/dec : increment / decrement requests (both high = activity, no move)
//   fast    : step by FAST_STEP instead of 1
//   setval  : load SET_VAL (overrides inc/dec/fast)
//   hold    : freeze the decay counter and suppress drift
//   value   : current resource value
//   level   : top LEVEL_BITS of value
//   at_max  : value is all ones
//   at_min  : value is zero
//   state   : 0=BASELINE, 1=ACTIVE, 2=DRIFT
module homeostatic_resource #(
   parameter int N            = 7,
   parameter int DEFAULT_VAL  = 64,
   parameter int SET_VAL      = 64,
   parameter int FAST_STEP    = 3,
   parameter int DECAY_PERIOD = 16,
   parameter int LEVEL_BITS   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inc,
   input  logic                  dec,
   input  logic                  fast,
   input  logic                  setval,
   input  logic                  hold,
   output logic [N-1:0]          value,
   output logic [LEVEL_BITS-1:0] level,
   output logic                  at_max,
   output logic                  at_min,
   output logic [1:0]            state
);

   localparam int CW = $clog2(DECAY_PERIOD);
   localparam logic [N-1:0]  DEF_V  = N'(DEFAULT_VAL);
   localparam logic [N-1:0]  SET_V  = N'(SET_VAL);
   localparam logic [N-1:0]  MAX_V  = {N{1'b1}};
   localparam logic [CW-1:0] CNT_TOP = CW'(DECAY_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_BASELINE = 2'd0,
      ST_ACTIVE   = 2'd1,
      ST_DRIFT    = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  value_q, value_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          activity;
   logic          drift_fire;
   logic [N-1:0]  step;
   logic [N:0]    sum;

   assign activity   = setval | inc | dec;
   // Drift fires only on the last count of an idle, unheld period.
   assign drift_fire = !activity && !hold && (cnt_q == CNT_TOP);
   assign step       = fast ? N'(FAST_STEP) : N'(1);
   // One extra bit so the increment can be saturated instead of wrapping.
   assign sum        = {1'b0, value_q} + {1'b0, step};

   // Value and decay counter next-state
   always_comb begin
      value_d = value_q;
      cnt_d   = cnt_q;
      if (setval) begin
         value_d = SET_V;
         cnt_d   = '0;
      end else if (inc ^ dec) begin
         cnt_d = '0;
         if (inc) begin
            value_d = sum[N] ? MAX_V : sum[N-1:0];
         end else begin
            value_d = (value_q >= step) ? (value_q - step) : '0;
         end
      end else if (inc & dec) begin
         cnt_d = '0;
      end else if (drift_fire) begin
         cnt_d = '0;
         if (value_q < DEF_V) begin
            value_d = value_q + N'(1);
         end else if (value_q > DEF_V) begin
            value_d = value_q - N'(1);
         end
      end else if (!hold) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // State machine next-state: baseline wins whenever the value lands on
   // DEFAULT_VAL, so state always agrees with the value it is registered with.
   always_comb begin
      state_d = state_q;
      if (value_d == DEF_V) begin
         state_d = ST_BASELINE;
      end else if (activity) begin
         state_d = ST_ACTIVE;
      end else if (drift_fire) begin
         state_d = ST_DRIFT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= DEF_V;
         cnt_q   <= '0;
         state_q <= ST_BASELINE;
      end else begin
         value_q <= value_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   assign value  = value_q;
   assign level  = value_q[N-1 -: LEVEL_BITS];
   assign at_max = (value_q == MAX_V);
   assign at_min = (value_q == '0);
   assign state  = state_q;

endmodule

// File: tb/tb_homeostatic_resource.sv
// tb_homeostatic_resource
//   Bench for homeostatic_resource with default parameters. Every driven cycle
//   advances an integer reference model; the expected {state, value} is pushed
//   into exp_q and popped/compared one clock later, after the DUT edge.
//   Directed scenarios also assert fixed constant values at key points.
module tb_homeostatic_resource;

   localparam int N   = 7;
   localparam int W   = N + 2;
   localparam int DEF = 64;
   localparam int SETV = 64;
   localparam int FST = 3;
   localparam int DP  = 16;
   localparam int MAXV = 127;

   logic         clk = 1'b0;
   logic         rst, inc, dec, fast, setval, hold;
   logic [N-1:0] value;
   logic [1:0]   level;
   logic         at_max, at_min;
   logic [1:0]   state;

   logic [W-1:0] exp_q[$];

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   int m_val;
   int m_cnt;
   int m_st;

   homeostatic_resource dut (
      .clk    (clk),
      .rst    (rst),
      .inc    (inc),
      .dec    (dec),
      .fast   (fast),
      .setval (setval),
      .hold   (hold),
      .value  (value),
      .level  (level),
      .at_max (at_max),
      .at_min (at_min),
      .state  (state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      rst = 1'b1; inc = 1'b0; dec = 1'b0; fast = 1'b0; setval = 1'b0; hold = 1'b0;
      m_val = 0; m_cnt = 0; m_st = 0;
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: one clock edge of behaviour from the requirement text.
   task automatic model_step(input bit r, input bit i, input bit d, input bit f,
                             input bit s, input bit h);
      int  stp;
      bit  act;
      bit  fired;
      stp   = f ? FST : 1;
      act   = s | i | d;
      fired = 1'b0;
      if (r) begin
         m_val = DEF; m_cnt = 0; m_st = 0;
         return;
      end
      if (s) begin
         m_val = SETV; m_cnt = 0;
      end else if (i && !d) begin
         m_val = (m_val + stp > MAXV) ? MAXV : m_val + stp; m_cnt = 0;
      end else if (d && !i) begin
         m_val = (m_val - stp < 0) ? 0 : m_val - stp; m_cnt = 0;
      end else if (i && d) begin
         m_cnt = 0;
      end else if (!h) begin
         if (m_cnt == DP - 1) begin
            fired = 1'b1;
            m_cnt = 0;
            if (m_val < DEF) m_val++;
            else if (m_val > DEF) m_val--;
         end else begin
            m_cnt++;
         end
      end
      if (m_val == DEF) m_st = 0;
      else if (act)     m_st = 1;
      else if (fired)   m_st = 2;
   endtask

   // Driver: apply inputs away from the edge, push expectation, then compare
   // everything the DUT shows just after the edge.
   task automatic drive(input bit r, input bit i, input bit d, input bit f,
                        input bit s, input bit h);
      logic [W-1:0] e;
      int ev;
      @(negedge clk);
      rst = r; inc = i; dec = d; fast = f; setval = s; hold = h;
      model_step(r, i, d, f, s, h);
      exp_q.push_back({m_st[1:0], m_val[N-1:0]});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check_eq("queue_underflow", 0, 1);
      end else begin
         e  = exp_q.pop_front();
         ev = int'(e[N-1:0]);
         check_eq("value", int'(value), ev);
         check_eq("state", int'(state), int'(e[W-1:N]));
         check_eq("level", int'(level), ev >> (N - 2));
         check_eq("at_max", int'(at_max), (ev == MAXV) ? 1 : 0);
         check_eq("at_min", int'(at_min), (ev == 0) ? 1 : 0);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // reset and long idle at baseline
      do_reset();
      check_eq("rst_value", int'(value), 64);
      check_eq("rst_level", int'(level), 2);
      check_eq("rst_state", int'(state), 0);
      idle(100);
      check_eq("idle100_value", int'(value), 64);
      check_eq("idle100_state", int'(state), 0);

      // fast increments up to saturation
      for (int k = 0; k < 21; k++) drive(0, 1, 0, 1, 0, 0);
      check_eq("sat_value", int'(value), 127);
      check_eq("sat_at_max", int'(at_max), 1);
      check_eq("sat_level", int'(level), 3);
      drive(0, 1, 0, 1, 0, 0);
      drive(0, 1, 0, 0, 0, 0);
      check_eq("sat_hold_value", int'(value), 127);

      // down to 2, then fast decrement clamps at 0
      for (int k = 0; k < 41; k++) drive(0, 0, 1, 1, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      check_eq("at_two", int'(value), 2);
      drive(0, 0, 1, 1, 0, 0);
      check_eq("floor_value", int'(value), 0);
      check_eq("floor_at_min", int'(at_min), 1);
      idle(10);
      drive(0, 1, 1, 1, 0, 0);  // both: activity, clears counter, no move
      check_eq("both_value", int'(value), 0);
      idle(15);
      check_eq("both_no_drift_yet", int'(value), 0);
      idle(1);
      check_eq("both_drift_after16", int'(value), 1);

      // single inc then drift back to baseline on the 16th idle edge
      do_reset();
      drive(0, 1, 0, 0, 0, 0);
      check_eq("inc1_value", int'(value), 65);
      check_eq("inc1_state", int'(state), 1);
      idle(15);
      check_eq("idle15_value", int'(value), 65);
      idle(1);
      check_eq("idle16_value", int'(value), 64);
      check_eq("idle16_state", int'(state), 0);
      idle(40);
      check_eq("settled_value", int'(value), 64);

      // hold freezes the decay counter
      do_reset();
      drive(0, 1, 0, 1, 0, 0);
      drive(0, 1, 0, 1, 0, 0);
      check_eq("at_seventy", int'(value), 70);
      idle(10);
      for (int k = 0; k < 5; k++) drive(0, 0, 0, 0, 0, 1);
      idle(5);
      check_eq("pre_drift_value", int'(value), 70);
      check_eq("pre_drift_state", int'(state), 1);
      idle(1);
      check_eq("drift_value", int'(value), 69);
      check_eq("drift_state", int'(state), 2);

      // reset during drift overrides setval; counter starts fresh
      idle(7);
      drive(1, 0, 0, 0, 1, 0);
      check_eq("rst_drift_value", int'(value), 64);
      check_eq("rst_drift_state", int'(state), 0);
      drive(0, 1, 0, 0, 0, 0);
      idle(15);
      check_eq("fresh_cnt_value", int'(value), 65);
      idle(1);
      check_eq("fresh_cnt_drift", int'(value), 64);

      // setval beats inc
      for (int k = 0; k < 18; k++) drive(0, 0, 1, 1, 0, 0);
      check_eq("at_ten", int'(value), 10);
      drive(0, 1, 0, 1, 1, 0);
      check_eq("setval_value", int'(value), 64);
      check_eq("setval_state", int'(state), 0);

      // randomized traffic, biased toward idle so drift gets exercised
      for (int k = 0; k < 1500; k++) begin
         int sel;
         sel = $urandom_range(0, 99);
         if (sel < 2)       drive(1, 0, 0, 0, 0, 0);
         else if (sel < 5)  drive(0, 1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
                                  1'($urandom_range(0,1)), 1, 0);
         else if (sel < 25) drive(0, 1, 0, 1'($urandom_range(0,1)), 0, 0);
         else if (sel < 45) drive(0, 0, 1, 1'($urandom_range(0,1)), 0, 0);
         else if (sel < 48) drive(0, 1, 1, 0, 0, 0);
         else if (sel < 60) drive(0, 0, 0, 0, 0, 1);
         else               drive(0, 0, 0, 0, 0, 0);
      end

      check_eq("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
